serial_frame_receiver: RTL

//  Serial-to-parallel receiver: the far end of the universal shift-register serializer.

---
 rtl/serial_frame_receiver_if.sv | 26 ++
 rtl/serial_frame_receiver.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/serial_frame_receiver_if.sv
// Bit-stream, acknowledge and result/flag signals between a serial frame source/consumer and the receiver.
interface serial_frame_receiver_if #(
  parameter int WIDTH = 8
);
  logic             BIT_EN;
  logic             Si;
  logic             DIR;
  logic             ACK;
  logic [WIDTH-1:0] Q;
  logic             RDY;
  logic             VALID;
  logic             BUSY;
  logic             FERR;
  logic             OVR;
  logic             PERR;

  modport master (
    output BIT_EN, Si, DIR, ACK,
    input  Q, RDY, VALID, BUSY, FERR, OVR, PERR
  );

  modport slave (
    input  BIT_EN, Si, DIR, ACK,
    output Q, RDY, VALID, BUSY, FERR, OVR, PERR
  );
endinterface

// File: rtl/serial_frame_receiver.sv
// Framed serial-to-parallel receiver (LSB/MSB first); Q/VALID one cycle after the stop-bit sample, RDY held until ACK.
// Define PARITY_EN to add a parity bit between data and stop (PARITY_ODD selects odd parity).
module serial_frame_receiver #(
  parameter int WIDTH      = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic                    CP,
  input  logic                    CR,
  serial_frame_receiver_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  if (WIDTH < 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_cfg_err
    $error("serial_frame_receiver: WIDTH must be >= 2 and PARITY_ODD 0 or 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    DATA,
`ifdef PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             dir_l, dir_nxt;
  logic [WIDTH-1:0] q;
  logic             rdy, ovr, valid, ferr;
  logic             good, stop_bad;
`ifdef PARITY_EN
  logic             par_bad, par_bad_nxt;
  logic             par_fail;
  logic             perr;
`endif

  always_ff @(posedge CP or posedge CR) begin
    if (CR) state <= IDLE;
    else    state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
    dir_nxt   = dir_l;
    good      = 1'b0;
    stop_bad  = 1'b0;
`ifdef PARITY_EN
    par_bad_nxt = par_bad;
    par_fail    = 1'b0;
`endif
    if (bus.BIT_EN) begin
      case (state)
        IDLE: begin
          if (!bus.Si) begin
            state_nxt = DATA;
            cnt_nxt   = '0;
            dir_nxt   = bus.DIR;
          end
        end
        DATA: begin
          // dir_l=0: first bit ends up in bit 0; dir_l=1: first bit ends up in the MSB
          sreg_nxt = dir_l ? {sreg[WIDTH-2:0], bus.Si} : {bus.Si, sreg[WIDTH-1:1]};
          cnt_nxt  = cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            cnt_nxt = '0;
`ifdef PARITY_EN
            state_nxt   = PARITY;
            par_bad_nxt = 1'b0;
`else
            state_nxt = STOP;
`endif
          end
        end
`ifdef PARITY_EN
        PARITY: begin
          par_bad_nxt = bus.Si != ((^sreg) ^ (PARITY_ODD != 0));
          state_nxt   = STOP;
        end
`endif
        STOP: begin
          state_nxt = IDLE;
          if (!bus.Si) stop_bad = 1'b1;
`ifdef PARITY_EN
          else if (par_bad) par_fail = 1'b1;
`endif
          else good = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      sreg  <= '0;
      cnt   <= '0;
      dir_l <= 1'b0;
      q     <= '0;
      rdy   <= 1'b0;
      ovr   <= 1'b0;
      valid <= 1'b0;
      ferr  <= 1'b0;
`ifdef PARITY_EN
      par_bad <= 1'b0;
      perr    <= 1'b0;
`endif
    end else begin
      sreg  <= sreg_nxt;
      cnt   <= cnt_nxt;
      dir_l <= dir_nxt;
      valid <= good;
      ferr  <= stop_bad;
      if (good) q <= sreg;
      // a completion wins over ACK for RDY; ACK wins over a completion for OVR
      if (good)         rdy <= 1'b1;
      else if (bus.ACK) rdy <= 1'b0;
      if (bus.ACK)          ovr <= 1'b0;
      else if (good && rdy) ovr <= 1'b1;
`ifdef PARITY_EN
      par_bad <= par_bad_nxt;
      perr    <= par_fail;
`endif
    end
  end

  assign bus.Q     = q;
  assign bus.RDY   = rdy;
  assign bus.VALID = valid;
  assign bus.BUSY  = (state != IDLE);
  assign bus.FERR  = ferr;
  assign bus.OVR   = ovr;
`ifdef PARITY_EN
  assign bus.PERR  = perr;
`else
  assign bus.PERR  = 1'b0;
`endif

endmodule
